// File: rtl/uart_tx_buffer.sv
// Transmit holding FIFO between the CPU write port and the UART shift engine.
// Queues up to DEPTH characters and hands them out one at a time via DOIT/DONE.
module uart_tx_buffer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         WRITE,
    input  logic [DATA_W-1:0]            OUT_PORT,
    input  logic                         DONE,
    input  logic                         CLR_OVR,
    output logic [DATA_W-1:0]            LOAD_DATA,
    output logic                         DOIT,
    output logic                         TXRDY,
    output logic                         TXEMPTY,
    output logic                         OVERRUN,
    output logic [$clog2(DEPTH):0]       COUNT
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned PTR_W = CNT_W - 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] load_q, load_d;
    logic              doit_q, doit_d;
    logic              txrdy_q, txrdy_d;
    logic              txempty_q, txempty_d;
    logic              overrun_q, overrun_d;

    logic push, drop, pop;

    // Push/drop judged on the pre-edge count, so a same-cycle pop never rescues a full write.
    always_comb begin
        push      = WRITE && (count_q != CNT_W'(DEPTH));
        drop      = WRITE && (count_q == CNT_W'(DEPTH));
        pop       = !doit_q && (count_q != '0);

        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        load_d    = load_q;
        doit_d    = doit_q;
        overrun_d = overrun_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        // DONE only clears DOIT; the next pop waits a cycle to give the engine a low gap.
        if (pop) begin
            load_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            doit_d   = 1'b1;
        end else if (doit_q && DONE) begin
            doit_d   = 1'b0;
        end

        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

        if (drop) begin
            overrun_d = 1'b1;
        end else if (CLR_OVR) begin
            overrun_d = 1'b0;
        end

        txrdy_d   = (count_d != CNT_W'(DEPTH));
        txempty_d = (count_d == '0) && !doit_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            load_q    <= '0;
            doit_q    <= 1'b0;
            txrdy_q   <= 1'b1;
            txempty_q <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            load_q    <= load_d;
            doit_q    <= doit_d;
            txrdy_q   <= txrdy_d;
            txempty_q <= txempty_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage needs no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= OUT_PORT;
        end
    end

    assign LOAD_DATA = load_q;
    assign DOIT      = doit_q;
    assign TXRDY     = txrdy_q;
    assign TXEMPTY   = txempty_q;
    assign OVERRUN   = overrun_q;
    assign COUNT     = count_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed self-checking bench for uart_tx_buffer (DATA_W=8, DEPTH=4).
module tb_uart_tx_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       WRITE;
    logic [7:0] OUT_PORT;
    logic       DONE;
    logic       CLR_OVR;
    logic [7:0] LOAD_DATA;
    logic       DOIT;
    logic       TXRDY;
    logic       TXEMPTY;
    logic       OVERRUN;
    logic [2:0] COUNT;

    int n_chk  = 0;
    int n_fail = 0;

    uart_tx_buffer #(.DATA_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .WRITE     (WRITE),
        .OUT_PORT  (OUT_PORT),
        .DONE      (DONE),
        .CLR_OVR   (CLR_OVR),
        .LOAD_DATA (LOAD_DATA),
        .DOIT      (DOIT),
        .TXRDY     (TXRDY),
        .TXEMPTY   (TXEMPTY),
        .OVERRUN   (OVERRUN),
        .COUNT     (COUNT)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; WRITE = 1'b0; OUT_PORT = '0; DONE = 1'b0; CLR_OVR = 1'b0;
        #3;
        n_chk++;
        if ({LOAD_DATA, DOIT, COUNT, TXRDY, TXEMPTY, OVERRUN} !== {8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got load=%h doit=%b cnt=%0d rdy=%b emp=%b ovr=%b", LOAD_DATA, DOIT, COUNT, TXRDY, TXEMPTY, OVERRUN);
        end
        tick;
        reset = 1'b0;
        tick;
        n_chk++;
        if ({TXRDY, TXEMPTY, COUNT, DOIT} !== {1'b1, 1'b1, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b emp=%b cnt=%0d doit=%b want 1 1 0 0", TXRDY, TXEMPTY, COUNT, DOIT);
        end
    endtask

    task automatic test_single;
        WRITE = 1'b1; OUT_PORT = 8'hA5;
        tick;  // edge 0
        WRITE = 1'b0;
        n_chk++;
        if ({COUNT, DOIT, TXEMPTY} !== {3'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL single_edge0: got cnt=%0d doit=%b emp=%b want 1 0 0", COUNT, DOIT, TXEMPTY);
        end
        tick;  // edge 1
        n_chk++;
        if ({COUNT, DOIT, LOAD_DATA, TXEMPTY} !== {3'd0, 1'b1, 8'hA5, 1'b0}) begin
            n_fail++;
            $display("FAIL single_edge1: got cnt=%0d doit=%b load=%h emp=%b want 0 1 a5 0", COUNT, DOIT, LOAD_DATA, TXEMPTY);
        end
        for (int i = 2; i < 9; i++) tick;
        DONE = 1'b1;
        tick;  // edge 9
        DONE = 1'b0;
        n_chk++;
        if ({DOIT, TXEMPTY, LOAD_DATA} !== {1'b0, 1'b1, 8'hA5}) begin
            n_fail++;
            $display("FAIL single_done: got doit=%b emp=%b load=%h want 0 1 a5", DOIT, TXEMPTY, LOAD_DATA);
        end
    endtask

    task automatic test_fill_overrun;
        for (int i = 1; i <= 6; i++) begin
            WRITE = 1'b1; OUT_PORT = 8'(i);
            tick;
            if (i == 5) begin
                n_chk++;
                if ({COUNT, TXRDY, OVERRUN, LOAD_DATA} !== {3'd4, 1'b0, 1'b0, 8'h01}) begin
                    n_fail++;
                    $display("FAIL fill_full: got cnt=%0d rdy=%b ovr=%b load=%h want 4 0 0 01", COUNT, TXRDY, OVERRUN, LOAD_DATA);
                end
            end
        end
        WRITE = 1'b0;
        n_chk++;
        if ({COUNT, TXRDY, OVERRUN, DOIT} !== {3'd4, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL fill_drop: got cnt=%0d rdy=%b ovr=%b doit=%b want 4 0 1 1", COUNT, TXRDY, OVERRUN, DOIT);
        end
        for (int k = 2; k <= 5; k++) begin
            DONE = 1'b1;
            tick;
            DONE = 1'b0;
            n_chk++;
            if (DOIT !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_gap_%0d: got doit=%b want 0", k, DOIT);
            end
            tick;
            n_chk++;
            if ({DOIT, LOAD_DATA, COUNT, TXRDY} !== {1'b1, 8'(k), 3'(5 - k), 1'b1}) begin
                n_fail++;
                $display("FAIL fill_pop_%0d: got doit=%b load=%h cnt=%0d rdy=%b want 1 %h %0d 1", k, DOIT, LOAD_DATA, COUNT, TXRDY, 8'(k), 5 - k);
            end
        end
        DONE = 1'b1;
        tick;
        DONE = 1'b0;
        n_chk++;
        if ({DOIT, TXEMPTY, OVERRUN} !== {1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL fill_drain: got doit=%b emp=%b ovr=%b want 0 1 1", DOIT, TXEMPTY, OVERRUN);
        end
    endtask

    task automatic test_simultaneous;
        CLR_OVR = 1'b1;
        tick;
        CLR_OVR = 1'b0;
        n_chk++;
        if (OVERRUN !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_ovr_alone: got ovr=%b want 0", OVERRUN);
        end
        for (int i = 0; i < 3; i++) begin
            WRITE = 1'b1; OUT_PORT = 8'(8'h11 + i);
            tick;
        end
        WRITE = 1'b0; DONE = 1'b1;
        tick;  // DOIT drops, two queued
        DONE = 1'b0; WRITE = 1'b1; OUT_PORT = 8'h14;
        tick;  // push and pop together
        n_chk++;
        if ({COUNT, DOIT, LOAD_DATA} !== {3'd2, 1'b1, 8'h12}) begin
            n_fail++;
            $display("FAIL push_pop: got cnt=%0d doit=%b load=%h want 2 1 12", COUNT, DOIT, LOAD_DATA);
        end
        for (int i = 0; i < 2; i++) begin
            OUT_PORT = 8'(8'h15 + i);
            tick;
        end
        WRITE = 1'b1; OUT_PORT = 8'hEE; DONE = 1'b1; CLR_OVR = 1'b1;
        tick;
        WRITE = 1'b0; DONE = 1'b0; CLR_OVR = 1'b0;
        n_chk++;
        if ({COUNT, OVERRUN, DOIT, TXRDY} !== {3'd4, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL drop_with_done_clr: got cnt=%0d ovr=%b doit=%b rdy=%b want 4 1 0 0", COUNT, OVERRUN, DOIT, TXRDY);
        end
        tick;
        n_chk++;
        if ({COUNT, TXRDY, DOIT, LOAD_DATA} !== {3'd3, 1'b1, 1'b1, 8'h13}) begin
            n_fail++;
            $display("FAIL pop_from_full: got cnt=%0d rdy=%b doit=%b load=%h want 3 1 1 13", COUNT, TXRDY, DOIT, LOAD_DATA);
        end
        for (int k = 0; k < 3; k++) begin
            DONE = 1'b1;
            tick;
            DONE = 1'b0;
            tick;
            n_chk++;
            if (LOAD_DATA !== 8'(8'h14 + k)) begin
                n_fail++;
                $display("FAIL sim_drain_%0d: got load=%h want %h", k, LOAD_DATA, 8'(8'h14 + k));
            end
        end
        DONE = 1'b1;
        tick;
        DONE = 1'b0;
        CLR_OVR = 1'b1;
        tick;
        CLR_OVR = 1'b0;
        n_chk++;
        if ({OVERRUN, TXEMPTY} !== {1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL sim_end: got ovr=%b emp=%b want 0 1", OVERRUN, TXEMPTY);
        end
    endtask

    task automatic test_spurious_done;
        DONE = 1'b1;
        tick;
        DONE = 1'b0;
        tick;
        n_chk++;
        if ({DOIT, TXEMPTY, COUNT, TXRDY, LOAD_DATA} !== {1'b0, 1'b1, 3'd0, 1'b1, 8'h16}) begin
            n_fail++;
            $display("FAIL spurious_done: got doit=%b emp=%b cnt=%0d rdy=%b load=%h want 0 1 0 1 16", DOIT, TXEMPTY, COUNT, TXRDY, LOAD_DATA);
        end
    endtask

    task automatic test_wrap;
        int wr_idx = 0;
        int rd_idx = 0;
        int busy = 0;
        int cyc = 0;
        logic prev_doit = 1'b0;
        while (rd_idx < 10 && cyc < 300) begin
            if (DOIT && !prev_doit) begin
                n_chk++;
                if (LOAD_DATA !== 8'(8'h30 + rd_idx)) begin
                    n_fail++;
                    $display("FAIL wrap_order_%0d: got load=%h want %h", rd_idx, LOAD_DATA, 8'(8'h30 + rd_idx));
                end
                rd_idx++;
            end
            if (COUNT > 3'd4) begin
                n_chk++;
                n_fail++;
                $display("FAIL wrap_count: got cnt=%0d want <=4", COUNT);
            end
            prev_doit = DOIT;
            WRITE = (wr_idx < 10) && TXRDY && (cyc % 4 != 3);
            OUT_PORT = 8'(8'h30 + wr_idx);
            if (WRITE) wr_idx++;
            DONE = 1'b0;
            if (DOIT) begin
                busy++;
                if (busy == 3) begin
                    DONE = 1'b1;
                    busy = 0;
                end
            end
            tick;
            cyc++;
        end
        WRITE = 1'b0; DONE = 1'b0;
        n_chk++;
        if (rd_idx != 10 || OVERRUN !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_complete: got %0d chars ovr=%b want 10 0", rd_idx, OVERRUN);
        end
        DONE = 1'b1;
        tick;
        DONE = 1'b0;
        tick;
        n_chk++;
        if ({TXEMPTY, DOIT} !== {1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_idle: got emp=%b doit=%b want 1 0", TXEMPTY, DOIT);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 4; i++) begin
            WRITE = 1'b1; OUT_PORT = 8'(8'h40 + i);
            tick;
        end
        WRITE = 1'b0;
        n_chk++;
        if ({COUNT, DOIT} !== {3'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid_setup: got cnt=%0d doit=%b want 3 1", COUNT, DOIT);
        end
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if ({LOAD_DATA, DOIT, COUNT, TXRDY, TXEMPTY, OVERRUN} !== {8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async: got load=%h doit=%b cnt=%0d rdy=%b emp=%b ovr=%b", LOAD_DATA, DOIT, COUNT, TXRDY, TXEMPTY, OVERRUN);
        end
        #2 reset = 1'b0;
        tick;
        tick;
        n_chk++;
        if ({TXRDY, TXEMPTY, COUNT, DOIT} !== {1'b1, 1'b1, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_release: got rdy=%b emp=%b cnt=%0d doit=%b want 1 1 0 0", TXRDY, TXEMPTY, COUNT, DOIT);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_fill_overrun;
        test_simultaneous;
        test_spurious_done;
        test_wrap;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
